// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer with prefetch FIFO, redirect flush and misalignment/range halt
// Ports: clk_i/rst_ni (sync active-low); imem_addr_o/imem_inst_i combinational memory port;
// inst_o/pc_o/valid_o/ready_i decode handshake; redirect_i/redirect_pc_i control-flow change;
// halt_o/fault_o/fault_pc_o status. Define FETCH_PERF_CNT_EN for stall/full/flush counters.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] IMEM_BYTES = 32'd8192
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] full_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        halt_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {FETCH, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, fault_pc_n;
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic fault_n, empty, full, pop, push_try, oor, push;
  assign empty    = wptr == rptr;
  assign full     = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign pop      = !empty && ready_i;
  assign oor      = pc >= IMEM_BYTES;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign push_try = state == FETCH && !redirect_i && (!full || pop);
  assign push     = push_try && !oor;
  assign imem_addr_o = pc;
  assign valid_o  = !empty;
  assign halt_o   = state == HALT;
  assign inst_o   = empty ? 32'h0 : inst_mem[rptr[AW-1:0]];
  assign pc_o     = empty ? 32'h0 : pc_mem[rptr[AW-1:0]];
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fault_n    = fault_o;
    fault_pc_n = fault_pc_o;
    wptr_n     = push ? wptr + (AW+1)'(1) : wptr;
    rptr_n     = pop ? rptr + (AW+1)'(1) : rptr;
    if (redirect_i) begin
      wptr_n = '0;
      rptr_n = '0;
      if (redirect_pc_i[1:0] == 2'b00) begin
        pc_n    = redirect_pc_i;
        state_n = FETCH;
        fault_n = 1'b0;
      end else begin
        state_n    = HALT;
        fault_n    = 1'b1;
        fault_pc_n = redirect_pc_i;
      end
    end else if (push_try && oor) begin
      state_n    = HALT;
      fault_n    = 1'b1;
      fault_pc_n = pc;
    end else if (push) begin
      pc_n = pc + 32'd4;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      wptr       <= '0;
      rptr       <= '0;
      fault_o    <= 1'b0;
      fault_pc_o <= 32'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      fault_o    <= fault_n;
      fault_pc_o <= fault_pc_n;
    end
  end
  // storage needs no reset: pointers alone decide what is valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wptr[AW-1:0]]   <= pc;
      inst_mem[wptr[AW-1:0]] <= imem_inst_i;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o <= 32'h0;
      full_cnt_o  <= 32'h0;
      flush_cnt_o <= 32'h0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(valid_o && !ready_i && stall_cnt_o != '1);
      full_cnt_o  <= full_cnt_o + 32'(state == FETCH && full && !pop && full_cnt_o != '1);
      flush_cnt_o <= flush_cnt_o + 32'(redirect_i && flush_cnt_o != '1);
    end
  end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready = 1'b1;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] addr0, inst0, ipc0, pc0, fpc0, addr1, inst1, ipc1, pc1, fpc1;
  logic valid0, halt0, fault0, valid1, halt1, fault1;
  int total = 0;
  int bad = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] st0, fu0, fl0, st1, fu1, fl1;
`endif
  always #5 clk = ~clk;
  assign inst0 = 32'h1000_0000 + {2'b00, addr0[31:2]};
  assign inst1 = 32'h1000_0000 + {2'b00, addr1[31:2]};
  imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(4), .IMEM_BYTES(32'd8192)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(addr0), .imem_inst_i(inst0),
    .inst_o(ipc0), .pc_o(pc0), .valid_o(valid0), .ready_i(ready),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt_o(st0), .full_cnt_o(fu0), .flush_cnt_o(fl0),
`endif
    .halt_o(halt0), .fault_o(fault0), .fault_pc_o(fpc0));
  imem_fetch_ctrl #(.RESET_PC(32'h1FF8), .DEPTH(4), .IMEM_BYTES(32'd8192)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .imem_addr_o(addr1), .imem_inst_i(inst1),
    .inst_o(ipc1), .pc_o(pc1), .valid_o(valid1), .ready_i(1'b1),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt_o(st1), .full_cnt_o(fu1), .flush_cnt_o(fl1),
`endif
    .halt_o(halt1), .fault_o(fault1), .fault_pc_o(fpc1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    chk("rst_valid", 32'(valid0), 32'h0);
    chk("rst_pc_o", pc0, 32'h0);
    chk("rst_inst_o", ipc0, 32'h0);
    chk("rst_halt", 32'(halt0), 32'h0);
    chk("rst_fault", 32'(fault0), 32'h0);
    chk("rst_fault_pc", fpc0, 32'h0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_addr_u1", addr1, 32'h1FF8);
    rst_n = 1'b1;
    step();
    chk("t1_valid", 32'(valid0), 32'h1);
    chk("t1_pc0", pc0, 32'h0);
    chk("t1_inst0", ipc0, 32'h1000_0000);
    chk("u1_pc0", pc1, 32'h1FF8);
    step();
    chk("t1_pc1", pc0, 32'h4);
    chk("t1_inst1", ipc0, 32'h1000_0001);
    chk("u1_pc1", pc1, 32'h1FFC);
    chk("u1_halt_early", 32'(halt1), 32'h0);
    step();
    chk("t1_pc2", pc0, 32'h8);
    chk("t1_inst2", ipc0, 32'h1000_0002);
    chk("u1_valid_end", 32'(valid1), 32'h0);
    chk("u1_halt", 32'(halt1), 32'h1);
    chk("u1_fault", 32'(fault1), 32'h1);
    chk("u1_fault_pc", fpc1, 32'h2000);
    chk("u1_addr_hold", addr1, 32'h2000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t2_valid", 32'(valid0), 32'h1);
    chk("t2_addr_full", addr0, 32'h10);
    chk("t2_head", pc0, 32'h0);
    ready = 1'b1;
    step();
    chk("t2_pop1", pc0, 32'h4);
    step();
    chk("t2_pop2", pc0, 32'h8);
    step();
    chk("t2_pop3", pc0, 32'hC);
    chk("t2_pop3_inst", ipc0, 32'h1000_0003);
    step();
    chk("t2_pop4", pc0, 32'h10);
    chk("t2_pop4_inst", ipc0, 32'h1000_0004);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready = 1'b0;
    step();
    step();
    step();
    chk("t3_addr3", addr0, 32'hC);
    chk("t3_head", pc0, 32'h0);
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(valid0), 32'h0);
    chk("t3_flush_pc_o", pc0, 32'h0);
    chk("t3_addr_tgt", addr0, 32'h100);
    step();
    chk("t3_tgt_valid", 32'(valid0), 32'h1);
    chk("t3_tgt_pc", pc0, 32'h100);
    chk("t3_tgt_inst", ipc0, 32'h1000_0040);
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    chk("t4_halt", 32'(halt0), 32'h1);
    chk("t4_fault", 32'(fault0), 32'h1);
    chk("t4_fault_pc", fpc0, 32'h102);
    chk("t4_addr", addr0, 32'h104);
    step();
    step();
    step();
    chk("t4_nopush_valid", 32'(valid0), 32'h0);
    chk("t4_nopush_addr", addr0, 32'h104);
    chk("t4_fault_sticky", 32'(fault0), 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("t4_resume_fault", 32'(fault0), 32'h0);
    chk("t4_resume_halt", 32'(halt0), 32'h0);
    chk("t4_resume_addr", addr0, 32'h200);
    step();
    chk("t4_resume_pc", pc0, 32'h200);
    step();
    chk("t4_resume_pc2", pc0, 32'h204);
    ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h1FF4;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_halt", 32'(halt0), 32'h1);
    chk("t5_fault", 32'(fault0), 32'h1);
    chk("t5_fault_pc", fpc0, 32'h2000);
    chk("t5_valid", 32'(valid0), 32'h1);
    chk("t5_head", pc0, 32'h1FF4);
    rst_n = 1'b0;
    step();
    chk("t5_rst_valid", 32'(valid0), 32'h0);
    chk("t5_rst_fault", 32'(fault0), 32'h0);
    chk("t5_rst_halt", 32'(halt0), 32'h0);
    chk("t5_rst_addr", addr0, 32'h0);
    chk("t5_rst_pc_o", pc0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_rst_stall_cnt", st0, 32'h0);
    chk("t5_rst_full_cnt", fu0, 32'h0);
    chk("t5_rst_flush_cnt", fl0, 32'h0);
`endif
    rst_n = 1'b1;
    step();
    chk("t5_restart", pc0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
